// File: rtl/audio_i2s_tx.sv
// I2S (Philips) stereo DAC transmitter with a one-pair holding register and saturating underrun count.
// Define I2S_LJ_FORMAT_EN for left-justified framing (no one-bit MSB delay).
module audio_i2s_tx #(
   parameter int SAMPLE_W = 24,
   parameter int SLOT_W   = 32,
   parameter int BCLK_DIV = 4
) (
   input  logic                OSC_CLK,
   input  logic                reset_reg,
   input  logic [SAMPLE_W-1:0] lsound_in,
   input  logic [SAMPLE_W-1:0] rsound_in,
   input  logic                in_valid,
   output logic                in_ready,
   output logic                AUD_BCLK,
   output logic                AUD_DACLRCK,
   output logic                AUD_DACDAT,
   output logic                frame_start,
   output logic [7:0]          underrun_cnt
);

   localparam int unsigned FRAME_BITS = 2 * SLOT_W;
   localparam int unsigned BW         = $clog2(FRAME_BITS);
   localparam int unsigned DW         = $clog2(BCLK_DIV);
   localparam int unsigned DIV_LAST   = BCLK_DIV - 1;
   localparam int unsigned DIV_HALF   = BCLK_DIV / 2;
   localparam int unsigned BIT_LAST   = FRAME_BITS - 1;

`ifdef I2S_LJ_FORMAT_EN
   localparam int L_FIRST = 0;
`else
   localparam int L_FIRST = 1;
`endif
   localparam int L_LAST  = L_FIRST + SAMPLE_W - 1;
   localparam int R_FIRST = L_FIRST + SLOT_W;
   localparam int R_LAST  = R_FIRST + SAMPLE_W - 1;

   if (SAMPLE_W < 1 || SAMPLE_W > SLOT_W) begin : g_bad_sample_w
      $error("audio_i2s_tx: SAMPLE_W must satisfy 1 <= SAMPLE_W <= SLOT_W");
   end
   if (BCLK_DIV < 2 || (BCLK_DIV % 2) != 0) begin : g_bad_bclk_div
      $error("audio_i2s_tx: BCLK_DIV must be even and >= 2");
   end

   logic [DW-1:0]       div_cnt,  div_nxt;
   logic [BW-1:0]       bit_cnt,  bit_nxt;
   logic [SAMPLE_W-1:0] hold_l,   hold_l_nxt;
   logic [SAMPLE_W-1:0] hold_r,   hold_r_nxt;
   logic [SAMPLE_W-1:0] shift_l,  shift_l_nxt;
   logic [SAMPLE_W-1:0] shift_r,  shift_r_nxt;
   logic                ready_nxt, bclk_nxt, lrck_nxt, dat_nxt, fs_nxt;
   logic [7:0]          ur_nxt;
   logic                adv, wrap, xfer;
   logic [SAMPLE_W-1:0] ld_l, ld_r;
   int                  bn;

   // Next-state: counters, handshake, frame load and serialiser.
   always_comb begin
      div_nxt     = div_cnt;
      bit_nxt     = bit_cnt;
      hold_l_nxt  = hold_l;
      hold_r_nxt  = hold_r;
      ready_nxt   = in_ready;
      ur_nxt      = underrun_cnt;
      dat_nxt     = AUD_DACDAT;
      ld_l        = shift_l;
      ld_r        = shift_r;
      shift_l_nxt = shift_l;
      shift_r_nxt = shift_r;

      adv  = (div_cnt == DW'(DIV_LAST));
      wrap = adv && (bit_cnt == BW'(BIT_LAST));
      xfer = in_valid && in_ready;

      div_nxt = adv ? '0 : div_cnt + DW'(1);
      if (adv) begin
         bit_nxt = wrap ? '0 : bit_cnt + BW'(1);
      end

      if (wrap) begin
         if (!in_ready) begin
            ld_l      = hold_l;
            ld_r      = hold_r;
            ready_nxt = 1'b1;
         end else if (xfer) begin
            // Empty holding register: the new pair goes straight to the shifters.
            ld_l = lsound_in;
            ld_r = rsound_in;
         end else begin
            ld_l   = '0;
            ld_r   = '0;
            ur_nxt = (underrun_cnt == 8'hFF) ? underrun_cnt : underrun_cnt + 8'd1;
         end
      end else if (xfer) begin
         hold_l_nxt = lsound_in;
         hold_r_nxt = rsound_in;
         ready_nxt  = 1'b0;
      end

      shift_l_nxt = ld_l;
      shift_r_nxt = ld_r;
      bn          = int'(bit_nxt);
      // Data changes only as BCLK falls, i.e. when div_cnt returns to 0.
      if (adv) begin
         dat_nxt = 1'b0;
         if (bn >= L_FIRST && bn <= L_LAST) begin
            dat_nxt     = ld_l[SAMPLE_W-1];
            shift_l_nxt = ld_l << 1;
         end else if (bn >= R_FIRST && bn <= R_LAST) begin
            dat_nxt     = ld_r[SAMPLE_W-1];
            shift_r_nxt = ld_r << 1;
         end
      end

      bclk_nxt = (div_nxt >= DW'(DIV_HALF));
      lrck_nxt = (bit_nxt >= BW'(SLOT_W));
      fs_nxt   = (div_nxt == DW'(DIV_LAST)) && (bit_nxt == BW'(BIT_LAST));
   end

   always_ff @(posedge OSC_CLK or posedge reset_reg) begin
      if (reset_reg) begin
         div_cnt      <= '0;
         bit_cnt      <= '0;
         hold_l       <= '0;
         hold_r       <= '0;
         shift_l      <= '0;
         shift_r      <= '0;
         in_ready     <= 1'b1;
         AUD_BCLK     <= 1'b0;
         AUD_DACLRCK  <= 1'b0;
         AUD_DACDAT   <= 1'b0;
         frame_start  <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         div_cnt      <= div_nxt;
         bit_cnt      <= bit_nxt;
         hold_l       <= hold_l_nxt;
         hold_r       <= hold_r_nxt;
         shift_l      <= shift_l_nxt;
         shift_r      <= shift_r_nxt;
         in_ready     <= ready_nxt;
         AUD_BCLK     <= bclk_nxt;
         AUD_DACLRCK  <= lrck_nxt;
         AUD_DACDAT   <= dat_nxt;
         frame_start  <= fs_nxt;
         underrun_cnt <= ur_nxt;
      end
   end

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Self-checking bench for audio_i2s_tx against a cycle-indexed behavioural model of the frame.
// Honours I2S_LJ_FORMAT_EN when the design is built with it.
module tb_audio_i2s_tx;

   localparam int SW    = 24;
   localparam int SL    = 32;
   localparam int DIV   = 4;
   localparam int FB    = 2 * SL;
   localparam int FRAME = DIV * FB;

   logic          clk = 1'b0;
   logic          rst;
   logic [SW-1:0] l_in, r_in;
   logic          vld;
   logic          in_ready, bclk, lrck, dat, fs;
   logic [7:0]    ur;

   int            checks = 0;
   int            errors = 0;
   int            t;
   logic          exp_full;
   logic [SW-1:0] hold_l, hold_r, cur_l, cur_r;
   int            exp_ur;
   logic          last_acc;
   logic [63:0]   rx_dat, rx_lr;

   always #5 clk = ~clk;

   audio_i2s_tx dut (
      .OSC_CLK      (clk),
      .reset_reg    (rst),
      .lsound_in    (l_in),
      .rsound_in    (r_in),
      .in_valid     (vld),
      .in_ready     (in_ready),
      .AUD_BCLK     (bclk),
      .AUD_DACLRCK  (lrck),
      .AUD_DACDAT   (dat),
      .frame_start  (fs),
      .underrun_cnt (ur)
   );

   // Expected serial bit in frame slot b for a given loaded pair.
   function automatic logic exp_dat(input int b, input logic [SW-1:0] l, input logic [SW-1:0] r);
      logic [SW-1:0] v;
      v = '0;
`ifdef I2S_LJ_FORMAT_EN
      if (b >= 0 && b < SW)            v = l >> (SW - 1 - b);
      else if (b >= SL && b < SL + SW) v = r >> (SL + SW - 1 - b);
`else
      if (b >= 1 && b <= SW)                v = l >> (SW - b);
      else if (b >= SL + 1 && b <= SL + SW) v = r >> (SL + SW - b);
`endif
      return v[0];
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
      end
   endtask

   task automatic check_outputs();
      int d, b;
      d = t % DIV;
      b = (t / DIV) % FB;
      chk("bclk", 64'(bclk), 64'(d >= DIV / 2));
      chk("lrck", 64'(lrck), 64'(b >= SL));
      chk("dacdat", 64'(dat), 64'(exp_dat(b, cur_l, cur_r)));
      chk("frame_start", 64'(fs), 64'((t % FRAME) == FRAME - 1));
      chk("in_ready", 64'(in_ready), 64'(!exp_full));
      chk("underrun_cnt", 64'(ur), 64'(exp_ur));
      if (d == DIV / 2) begin
         rx_dat = {rx_dat[62:0], dat};
         rx_lr  = {rx_lr[62:0], lrck};
      end
   endtask

   // One clock: drive inputs, advance the model across the edge, then check.
   task automatic cycle(input logic v, input logic [SW-1:0] l, input logic [SW-1:0] r);
      logic xfer;
      vld  = v;
      l_in = l;
      r_in = r;
      xfer = v && !exp_full;
      if ((t % FRAME) == FRAME - 1) begin
         if (exp_full) begin
            cur_l = hold_l; cur_r = hold_r; exp_full = 1'b0;
         end else if (xfer) begin
            cur_l = l; cur_r = r;
         end else begin
            cur_l = '0; cur_r = '0;
            if (exp_ur < 255) exp_ur++;
         end
      end else if (xfer) begin
         hold_l = l; hold_r = r; exp_full = 1'b1;
      end
      last_acc = xfer;
      @(posedge clk);
      t++;
      @(negedge clk);
      check_outputs();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, '0, '0);
   endtask

   task automatic run_to_frame_end();
      while ((t % FRAME) != FRAME - 1) cycle(1'b0, '0, '0);
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      vld = 1'b0;
      #1;
      chk("rst_bclk", 64'(bclk), 64'(0));
      chk("rst_lrck", 64'(lrck), 64'(0));
      chk("rst_dat", 64'(dat), 64'(0));
      chk("rst_fs", 64'(fs), 64'(0));
      chk("rst_ur", 64'(ur), 64'(0));
      chk("rst_ready", 64'(in_ready), 64'(1));
      repeat (n) @(negedge clk);
      rst      = 1'b0;
      t        = 0;
      exp_full = 1'b0;
      cur_l    = '0;
      cur_r    = '0;
      hold_l   = '0;
      hold_r   = '0;
      exp_ur   = 0;
   endtask

   function automatic logic [63:0] exp_stream(input logic [SW-1:0] l, input logic [SW-1:0] r);
      logic [63:0] s;
      s = '0;
      for (int b = 0; b < FB; b++) s = {s[62:0], exp_dat(b, l, r)};
      return s;
   endfunction

   initial begin
      logic [SW-1:0] base, bl, br;
      logic [63:0]   golden;
      int            k, ur_before;
      rst = 1'b1; vld = 1'b0; l_in = '0; r_in = '0;
      t = 0; exp_full = 1'b0; cur_l = '0; cur_r = '0; hold_l = '0; hold_r = '0;
      exp_ur = 0; last_acc = 1'b0; rx_dat = '0; rx_lr = '0;
      @(negedge clk);

      // Reset and first frame with no input: one underrun.
      do_reset(10);
      idle(FRAME - 1);
      chk("first_fs", 64'(fs), 64'(1));
      idle(1);
      chk("first_underrun", 64'(ur), 64'(1));

      // Single directed pair offered mid-frame, transmitted in the next frame.
      idle(44);
      cycle(1'b1, 24'hABCDEF, 24'h123456);
      chk("single_accept", 64'(last_acc), 64'(1));
      run_to_frame_end();
      cycle(1'b0, '0, '0);
      run_to_frame_end();
`ifdef I2S_LJ_FORMAT_EN
      golden = {24'hABCDEF, 8'h0, 24'h123456, 8'h0};
`else
      golden = {1'b0, 24'hABCDEF, 7'h0, 1'b0, 24'h123456, 7'h0};
`endif
      chk("single_stream", rx_dat, golden);
      chk("single_lrck", rx_lr, {32'h0, 32'hFFFF_FFFF});
      chk("single_ur", 64'(ur), 64'(1));

      // Backpressure: valid held high with an incrementing stream.
      base = SW'($urandom);
      k = 0;
      ur_before = exp_ur;
      for (int i = 0; i < 4 * FRAME; i++) begin
         cycle(1'b1, base + SW'(k), ~(base + SW'(k)));
         if (last_acc) k++;
      end
      chk("bp_ur", 64'(ur), 64'(ur_before));
      chk("bp_ready_low", 64'(in_ready), 64'(0));
      run_to_frame_end();
      cycle(1'b0, '0, '0);
      run_to_frame_end();
      chk("bp_drained_ur", 64'(ur), 64'(ur_before));

      // Bypass: offer only during the frame_start cycle with the holding register empty.
      cycle(1'b0, '0, '0);
      run_to_frame_end();
      chk("byp_fs", 64'(fs), 64'(1));
      chk("byp_ready", 64'(in_ready), 64'(1));
      ur_before = exp_ur;
      bl = SW'($urandom);
      br = SW'($urandom);
      cycle(1'b1, bl, br);
      chk("byp_ready_after", 64'(in_ready), 64'(1));
      chk("byp_ur", 64'(ur), 64'(ur_before));
      run_to_frame_end();
      chk("byp_stream", rx_dat, exp_stream(bl, br));

      // Reset mid-frame with a pair held: the held pair must never appear.
      cycle(1'b0, '0, '0);
      cycle(1'b1, SW'($urandom) | SW'(1), SW'($urandom) | SW'(1));
      while ((t % FRAME) != 40 * DIV) cycle(1'b0, '0, '0);
      chk("mid_ready_low", 64'(in_ready), 64'(0));
      do_reset(3);
      idle(2 * FRAME);
      chk("mid_ur", 64'(ur), 64'(2));
      chk("mid_stream", rx_dat, 64'(0));

      // Underrun saturation over 300 silent frames.
      idle(300 * FRAME);
      chk("sat_ur", 64'(ur), 64'(255));
      chk("sat_stream", rx_dat, 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
